// File: rtl/bank_arb_pkg.sv
// Shared types and helpers for the dual-requester bank arbiter.
// Bank geometry, the priority encoding and the read-response tag live here.
package bank_arb_pkg;

  localparam int BANK_BITS  = 2;
  localparam int NUM_BANKS  = 2 ** BANK_BITS;
  localparam int ADDR_W_MAX = 32;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  typedef struct packed {
    logic                 valid;
    logic [BANK_BITS-1:0] bank;
  } rsp_tag_t;

  // Bank select is the top BANK_BITS bits of an addr_width-wide word address.
  function automatic logic [BANK_BITS-1:0] bank_of(input logic [ADDR_W_MAX-1:0] addr,
                                                   input int                    addr_width);
    return addr[addr_width-1 -: BANK_BITS];
  endfunction

endpackage

// File: rtl/rd_resp_pipe.sv
// READ_LATENCY-deep shift register of read-response tags for one requester.
// Synchronous active-low clear discards any in-flight reads.
module rd_resp_pipe
  import bank_arb_pkg::*;
#(
  parameter int READ_LATENCY = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  rsp_tag_t i_tag,
  output rsp_tag_t o_tag
);

  rsp_tag_t r_stage [READ_LATENCY];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < READ_LATENCY; i++) begin
        r_stage[i] <= '0;
      end
    end else begin
      r_stage[0] <= i_tag;
      for (int i = 1; i < READ_LATENCY; i++) begin
        r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_tag = r_stage[READ_LATENCY-1];

endmodule

// File: rtl/bank_port_arbiter.sv
// Dual-requester scheduler for a 4-bank memory: parallel grants to distinct
// banks, round-robin on same-bank conflicts, latency-matched read return.
module bank_port_arbiter
  import bank_arb_pkg::*;
#(
  parameter int ADDR_WIDTH   = 8,
  parameter int DATA_WIDTH   = 8,
  parameter int READ_LATENCY = 2
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        i_a_req,
  input  logic                                        i_b_req,
  input  logic                                        i_a_we,
  input  logic                                        i_b_we,
  input  logic [ADDR_WIDTH-1:0]                       i_a_addr,
  input  logic [ADDR_WIDTH-1:0]                       i_b_addr,
  input  logic [DATA_WIDTH-1:0]                       i_a_wdata,
  input  logic [DATA_WIDTH-1:0]                       i_b_wdata,
  output logic                                        o_a_gnt,
  output logic                                        o_b_gnt,
  output logic                                        o_a_rvalid,
  output logic                                        o_b_rvalid,
  output logic [DATA_WIDTH-1:0]                       o_a_rdata,
  output logic [DATA_WIDTH-1:0]                       o_b_rdata,
  output logic [NUM_BANKS-1:0]                        o_bank_en,
  output logic [NUM_BANKS-1:0]                        o_bank_we,
  output logic [NUM_BANKS*(ADDR_WIDTH-BANK_BITS)-1:0] o_bank_addr,
  output logic [NUM_BANKS*DATA_WIDTH-1:0]             o_bank_wdata,
  input  logic [NUM_BANKS*DATA_WIDTH-1:0]             i_bank_rdata,
  output logic [15:0]                                 o_conflict_cnt
);

  localparam int LOC_W = ADDR_WIDTH - BANK_BITS;

  // Handshake: a requester raises req with stable we/addr/wdata and holds them
  // until it sees gnt=1; the transfer happens on the cycle where req & gnt.

  logic [BANK_BITS-1:0] w_a_bank;
  logic [BANK_BITS-1:0] w_b_bank;
  logic [LOC_W-1:0]     w_a_loc;
  logic [LOC_W-1:0]     w_b_loc;
  logic                 w_conflict;
  logic                 w_a_gnt;
  logic                 w_b_gnt;
  port_e                r_prio;
  logic [15:0]          r_conflict_cnt;

  assign w_a_bank = bank_of(ADDR_W_MAX'(i_a_addr), ADDR_WIDTH);
  assign w_b_bank = bank_of(ADDR_W_MAX'(i_b_addr), ADDR_WIDTH);
  assign w_a_loc  = i_a_addr[LOC_W-1:0];
  assign w_b_loc  = i_b_addr[LOC_W-1:0];

  assign w_conflict = rst_n & i_a_req & i_b_req & (w_a_bank == w_b_bank);

  // Grants are suppressed while reset is asserted.
  assign w_a_gnt = rst_n & i_a_req & (~w_conflict | (r_prio == PORT_A));
  assign w_b_gnt = rst_n & i_b_req & (~w_conflict | (r_prio == PORT_B));

  assign o_a_gnt = w_a_gnt;
  assign o_b_gnt = w_b_gnt;

  // Priority passes to the loser of each conflict, giving strict alternation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_prio <= PORT_A;
    end else if (w_conflict) begin
      r_prio <= (r_prio == PORT_A) ? PORT_B : PORT_A;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_conflict_cnt <= '0;
    end else if (w_conflict && (r_conflict_cnt != 16'hFFFF)) begin
      r_conflict_cnt <= r_conflict_cnt + 16'd1;
    end
  end

  assign o_conflict_cnt = r_conflict_cnt;

  // Bank drive: at most one grant can target a given bank in any cycle.
  always_comb begin
    o_bank_en    = '0;
    o_bank_we    = '0;
    o_bank_addr  = '0;
    o_bank_wdata = '0;
    for (int k = 0; k < NUM_BANKS; k++) begin
      if (w_a_gnt && (w_a_bank == BANK_BITS'(k))) begin
        o_bank_en[k]                            = 1'b1;
        o_bank_we[k]                            = i_a_we;
        o_bank_addr[k*LOC_W +: LOC_W]           = w_a_loc;
        o_bank_wdata[k*DATA_WIDTH +: DATA_WIDTH] = i_a_wdata;
      end else if (w_b_gnt && (w_b_bank == BANK_BITS'(k))) begin
        o_bank_en[k]                            = 1'b1;
        o_bank_we[k]                            = i_b_we;
        o_bank_addr[k*LOC_W +: LOC_W]           = w_b_loc;
        o_bank_wdata[k*DATA_WIDTH +: DATA_WIDTH] = i_b_wdata;
      end
    end
  end

  rsp_tag_t w_a_tag_in;
  rsp_tag_t w_b_tag_in;
  rsp_tag_t w_a_tag_out;
  rsp_tag_t w_b_tag_out;

  assign w_a_tag_in.valid = i_a_req & w_a_gnt & ~i_a_we;
  assign w_a_tag_in.bank  = w_a_bank;
  assign w_b_tag_in.valid = i_b_req & w_b_gnt & ~i_b_we;
  assign w_b_tag_in.bank  = w_b_bank;

  rd_resp_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_a_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_a_tag_in),
    .o_tag (w_a_tag_out)
  );

  rd_resp_pipe #(
    .READ_LATENCY(READ_LATENCY)
  ) u_b_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .i_tag (w_b_tag_in),
    .o_tag (w_b_tag_out)
  );

  // Return data is steered from the bank recorded at grant time.
  assign o_a_rvalid = w_a_tag_out.valid;
  assign o_b_rvalid = w_b_tag_out.valid;
  assign o_a_rdata  = w_a_tag_out.valid ?
                      i_bank_rdata[int'(w_a_tag_out.bank)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign o_b_rdata  = w_b_tag_out.valid ?
                      i_bank_rdata[int'(w_b_tag_out.bank)*DATA_WIDTH +: DATA_WIDTH] : '0;

endmodule

// File: doc/bank_port_arbiter.md
Name: bank_port_arbiter

Overview:
- Dual-requester scheduler for the 4-bank memory array. Shares the banks between requester A and requester B on a single clock.
- Grants both requesters in the same cycle when they target different banks. Resolves same-bank conflicts round-robin.
- Tracks in-flight reads so each requester's read data is returned exactly READ_LATENCY cycles after its grant, routed from the correct bank.

Parameters:
- ADDR_WIDTH, 8, full word address width; top BANK_BITS bits select the bank.
- DATA_WIDTH, 8, data word width.
- BANK_BITS, 2, bank-select bits; NUM_BANKS = 2**BANK_BITS = 4.
- READ_LATENCY, 2, bank read latency in cycles; legal range 1..8.

Ports:
- clk  input  1  sole clock; all state on posedge.
- rst_n  input  1  synchronous, active-low reset.
- i_a_req, i_b_req  input  1  request valid, held until granted.
- i_a_we, i_b_we  input  1  1 = write, 0 = read.
- i_a_addr, i_b_addr  input  ADDR_WIDTH  word address.
- i_a_wdata, i_b_wdata  input  DATA_WIDTH  write data.
- o_a_gnt, o_b_gnt  output  1  combinational grant; a transfer occurs on a cycle with req & gnt.
- o_a_rvalid, o_b_rvalid  output  1  read data valid.
- o_a_rdata, o_b_rdata  output  DATA_WIDTH  read data.
- o_bank_en  output  NUM_BANKS  per-bank access enable.
- o_bank_we  output  NUM_BANKS  per-bank write enable.
- o_bank_addr  output  NUM_BANKS*(ADDR_WIDTH-BANK_BITS)  per-bank local address, flattened, bank 0 in LSBs.
- o_bank_wdata  output  NUM_BANKS*DATA_WIDTH  per-bank write data, flattened.
- i_bank_rdata  input  NUM_BANKS*DATA_WIDTH  per-bank read data, valid READ_LATENCY cycles after en & !we.
- o_conflict_cnt  output  16  saturating count of conflict cycles.

Behaviour:
- Bank index = addr[ADDR_WIDTH-1 -: BANK_BITS]; local address = the remaining low bits.
- Different banks, or only one requester active: each active requester is granted combinationally in the same cycle.
- Same bank, both active: grant goes to the requester holding priority; the other sees gnt=0 and must hold req, addr, we and wdata stable.
- prio register (0 = A, 1 = B) update on each conflict cycle:
  - set to the loser;
  - left unchanged on non-conflict cycles.
  - Consequence: strict alternation under sustained conflict, so each requester waits at most 1 cycle.
- Bank drive is combinational from granted requests:
  - o_bank_en[k] = 1 iff some grant targets bank k;
  - we, addr and wdata come from the granted requester;
  - undriven banks output zeros.
- Read response pipeline, per requester: a READ_LATENCY-deep shift register of {valid, bank}.
  - Stage 0 is loaded with {req & gnt & !we, bank}.
  - o_x_rvalid = valid at the last stage.
  - o_x_rdata = i_bank_rdata slice selected by the last-stage bank index, registered-free mux.
  - o_x_rdata = 0 when rvalid = 0.
- Writes produce no response.
- Back-to-back reads to alternating banks sustain 1 read/cycle per requester; rvalid may be high on consecutive cycles.
- Simultaneous read on A and write on B to different banks: both proceed; A's rvalid is unaffected.
- o_conflict_cnt increments on each conflict cycle and saturates at 16'hFFFF (no wrap).
- Reset (rst_n=0 at a posedge):
  - prio=0, pipelines cleared, o_conflict_cnt=0;
  - in-flight reads are discarded, so no rvalid is produced for them after reset;
  - while rst_n=0, all grants and o_bank_en are forced to 0 combinationally.
- rvalid and rdata are 0 from the first posedge with rst_n=0 until READ_LATENCY cycles after the first post-reset read grant.

Decomposition:
- Package bank_arb_pkg:
  - BANK_BITS, NUM_BANKS and a localparam function for bank index extraction;
  - enum port_e {PORT_A, PORT_B} used for prio;
  - typedef rsp_tag_t {logic valid; logic [BANK_BITS-1:0] bank}.
- Sub-module rd_resp_pipe (parameter READ_LATENCY): shift register of rsp_tag_t with synchronous active-low clear. Instantiated once per requester; the output mux stays in the top.

Test Plan:
- Reset then A read addr 8'h40 (bank 1), B read addr 8'h80 (bank 2), same cycle, READ_LATENCY=2:
  - both gnt=1; o_bank_en=4'b0110;
  - 2 cycles later A_rvalid=B_rvalid=1 with bank1/bank2 data.
- A and B both read bank 3 (8'hC0, 8'hC4), held for 3 cycles after reset:
  - cycle0 grants A, cycle1 grants B (alternation);
  - o_conflict_cnt=1 after cycle0, 2 after cycle1.
- Sustained conflict for 10 cycles with both requesters re-requesting every cycle:
  - grants alternate A,B,A,B...;
  - never two consecutive grants to one requester.
- A writes 8'h55 to 8'h12 then reads 8'h12 (bank model attached):
  - the read returns 8'h55 after READ_LATENCY;
  - the write produces no rvalid.
- Issue an A read, then assert rst_n=0 one cycle later for 1 cycle:
  - no A_rvalid ever appears for that read;
  - o_bank_en=0 during reset;
  - o_conflict_cnt=0 afterwards.
- Force o_conflict_cnt near saturation (65535 conflict cycles):
  - the counter holds 16'hFFFF and does not wrap.
